// File: rtl/mpeg_bit_window.sv
// mpeg_bit_window
//   MPEG bitstream reader window. Holds a left-aligned W-bit window of
//   upcoming stream bits for the VLC/header decoders. Bytes arrive on a
//   valid/ready stream and are appended at one byte per cycle. Consumers
//   discard flush_n bits per accepted flush request. After the last byte,
//   the window drains with zero padding. A flush that asks for more bits
//   than are held raises the sticky underrun flag.
//
// Parameters
//   W      window width in bits (multiple of 8, 16..64)
//   CNT_W  width of bit counters and flush_n
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   in_valid     in_byte valid
//   in_byte      next stream byte, MSB first
//   in_last      marks the final byte of the stream
//   in_ready     byte accepted this cycle when high with in_valid
//   flush_valid  request to discard flush_n bits
//   flush_n      bits to discard (0..W; larger values are treated as
//                exceeding bit_cnt)
//   flush_ready  flush accepted when high with flush_valid
//   window       next W stream bits, MSB = next bit, unfilled LSBs zero
//   bit_cnt      number of valid bits in window
//   eos          the in_last byte has been accepted
//   underrun     sticky: a flush exceeded bit_cnt
//   bit_pos      (only with BITWIN_BITPOS_EN) running count of bits
//                discarded, modulo 2^32
//
// Optional feature macro: BITWIN_BITPOS_EN
//
// State | meaning
// FILL    | bit_cnt < W-7, stream still open; flushes held off
// READY   | bit_cnt >= W-7, stream still open; flushes accepted
// TAIL    | eos seen, bits still held
// DRAINED | eos seen, window empty
module mpeg_bit_window #(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             flush_valid,
  input  logic [CNT_W-1:0] flush_n,
  output logic             flush_ready,
  output logic [W-1:0]     window,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             eos,
  output logic             underrun
`ifdef BITWIN_BITPOS_EN
  ,
  output logic [31:0]      bit_pos
`endif
);

  localparam logic [1:0] ST_FILL    = 2'd0;
  localparam logic [1:0] ST_READY   = 2'd1;
  localparam logic [1:0] ST_TAIL    = 2'd2;
  localparam logic [1:0] ST_DRAINED = 2'd3;

  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_REFILL = CNT_W'(W - 8);
  localparam logic [CNT_W-1:0] CNT_READY  = CNT_W'(W - 7);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [W-1:0]     window_nxt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic             eos_nxt;
  logic             underrun_nxt;
  logic             flush_fire;
  logic             byte_fire;
  logic             over;
  logic [CNT_W-1:0] ins_sh;
  logic [CNT_W-1:0] drop_n;
  logic [W-1:0]     byte_ext;

  assign flush_ready = (state == ST_READY) || (state == ST_TAIL) || (state == ST_DRAINED);
  assign flush_fire  = flush_valid && flush_ready;
  assign in_ready    = !eos && (bit_cnt <= CNT_REFILL) && !flush_fire;
  assign byte_fire   = in_valid && in_ready;

  assign over     = flush_n > bit_cnt;
  // Only meaningful while in_ready is high (bit_cnt <= W-8), so never negative.
  assign ins_sh   = CNT_REFILL - bit_cnt;
  assign drop_n   = over ? bit_cnt : flush_n;
  assign byte_ext = {{(W-8){1'b0}}, in_byte};

  always_comb begin
    window_nxt   = window;
    bit_cnt_nxt  = bit_cnt;
    eos_nxt      = eos;
    underrun_nxt = underrun;
    if (flush_fire) begin
      if (over) begin
        window_nxt   = '0;
        bit_cnt_nxt  = '0;
        underrun_nxt = 1'b1;
      end else begin
        // A full-width flush must empty the window rather than wrap.
        window_nxt  = (flush_n >= CNT_FULL) ? '0 : (window << flush_n);
        bit_cnt_nxt = bit_cnt - flush_n;
      end
    end else if (byte_fire) begin
      window_nxt  = window | (byte_ext << ins_sh);
      bit_cnt_nxt = bit_cnt + CNT_W'(8);
      if (in_last) begin
        eos_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = ST_FILL;
    if (eos_nxt) begin
      state_nxt = (bit_cnt_nxt == '0) ? ST_DRAINED : ST_TAIL;
    end else begin
      state_nxt = (bit_cnt_nxt >= CNT_READY) ? ST_READY : ST_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FILL;
      window   <= '0;
      bit_cnt  <= '0;
      eos      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      window   <= window_nxt;
      bit_cnt  <= bit_cnt_nxt;
      eos      <= eos_nxt;
      underrun <= underrun_nxt;
    end
  end

`ifdef BITWIN_BITPOS_EN
  // Counts bits actually removed, so an underrun flush adds only what was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_pos <= '0;
    end else if (flush_fire) begin
      bit_pos <= bit_pos + 32'(drop_n);
    end
  end
`endif

endmodule

// File: tb/tb_mpeg_bit_window.sv
module tb_mpeg_bit_window;
  localparam int W     = 32;
  localparam int CNT_W = $clog2(W + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [7:0]       in_byte = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             flush_valid = 1'b0;
  logic [CNT_W-1:0] flush_n = '0;
  logic             flush_ready;
  logic [W-1:0]     window;
  logic [CNT_W-1:0] bit_cnt;
  logic             eos;
  logic             underrun;
`ifdef BITWIN_BITPOS_EN
  logic [31:0]      bit_pos;
`endif

  always #5 clk = ~clk;

  mpeg_bit_window #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last), .in_ready(in_ready),
    .flush_valid(flush_valid), .flush_n(flush_n), .flush_ready(flush_ready),
    .window(window), .bit_cnt(bit_cnt), .eos(eos), .underrun(underrun)
`ifdef BITWIN_BITPOS_EN
    , .bit_pos(bit_pos)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the pending stream as a plain queue of bits.
  bit          m_q[$];
  bit          m_eos = 1'b0;
  bit          m_unr = 1'b0;
  logic [31:0] m_pos = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_window();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (i < m_q.size()) w[W-1-i] = m_q[i];
    end
    return w;
  endfunction

  function automatic bit m_fready();
    return m_eos || (m_q.size() >= W - 7);
  endfunction

  function automatic bit m_iready(input bit fv);
    return !m_eos && (m_q.size() <= W - 8) && !(fv && m_fready());
  endfunction

  task automatic step(input bit r, input bit iv, input logic [7:0] b, input bit il,
                      input bit fv, input int fn);
    bit ff;
    bit bf;
    @(negedge clk);
    rst = r; in_valid = iv; in_byte = b; in_last = il;
    flush_valid = fv; flush_n = CNT_W'(fn);
    #1;
    ff = fv && m_fready();
    bf = iv && m_iready(fv);
    chk("in_ready", in_ready, m_iready(fv));
    chk("flush_ready", flush_ready, m_fready());
    @(posedge clk);
    if (r) begin
      m_q.delete(); m_eos = 0; m_unr = 0; m_pos = '0;
    end else if (ff) begin
      if (fn > m_q.size()) begin
        m_pos += 32'(m_q.size());
        m_q.delete();
        m_unr = 1;
      end else begin
        m_pos += 32'(fn);
        for (int k = 0; k < fn; k++) void'(m_q.pop_front());
      end
    end else if (bf) begin
      for (int k = 7; k >= 0; k--) m_q.push_back(b[k]);
      if (il) m_eos = 1;
    end
    #1;
    chk("window", window, m_window());
    chk("bit_cnt", bit_cnt, m_q.size());
    chk("eos", eos, m_eos);
    chk("underrun", underrun, m_unr);
`ifdef BITWIN_BITPOS_EN
    chk("bit_pos", bit_pos, m_pos);
`endif
    rst = 0; in_valid = 0; flush_valid = 0; in_last = 0;
  endtask

  initial begin
    logic [7:0] hdr [4];
    int fn;
    hdr[0] = 8'h00; hdr[1] = 8'h00; hdr[2] = 8'h01; hdr[3] = 8'hB3;

    step(1, 0, 8'h00, 0, 0, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_window", window, 0);

    // Sequence header start code, then partial flushes with a waiting byte.
    for (int i = 0; i < 4; i++) step(0, 1, hdr[i], 0, 0, 0);
    chk("hdr_window", window, 32'h000001B3);
    chk("hdr_full", bit_cnt, 32);
    step(0, 1, 8'h16, 0, 1, 5);
    chk("flush5_window", window, 32'h00003660);
    step(0, 1, 8'h16, 0, 0, 0);
    chk("held_byte_cnt", bit_cnt, 27);
    step(0, 1, 8'h16, 0, 1, 8);
    step(0, 1, 8'h16, 0, 0, 0);
    chk("refill_sh5", window, 32'h003662C0);

    // End of stream, drain, underrun.
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'hAB, 0, 0, 0);
    step(0, 1, 8'hCD, 1, 0, 0);
    chk("eos_set", eos, 1);
    step(0, 1, 8'hEE, 0, 1, 12);
    chk("tail_window", window, 32'hD0000000);
    step(0, 0, 8'h00, 0, 1, 8);
    chk("underrun_set", underrun, 1);
    step(0, 1, 8'h55, 0, 1, 0);

    // Reset mid-refill with a byte pending.
    step(0, 1, 8'h11, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h12, 0, 0, 0);
    step(0, 1, 8'h34, 0, 0, 0);
    step(1, 1, 8'h56, 0, 0, 0);
    chk("midrst_cnt", bit_cnt, 0);

    // Randomised traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      bit r;
      r = ($urandom_range(0, 199) == 0) || (m_eos && m_q.size() == 0 && $urandom_range(0, 3) == 0);
      if (m_eos) fn = $urandom_range(0, 40);
      else       fn = $urandom_range(0, m_q.size());
      step(r, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 29) == 0,
           $urandom_range(0, 1) == 1, fn);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
